score_ctrl: RTL and testbench

- Score scheduler for the game: arbitrates point awards from N_SRC requesters (enemy kills, bonus pickups, boss hits) round-robin.
- Applies each award to a two-digit BCD score, one point per cycle, saturating at 99.
- Tracks the session high score.
- Drives registered active-low 7-segment codes for the tens and ones digits to the board displays.

---
 rtl/score_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_score_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// -----------------------------------------------------------------------------
// score_ctrl
//
// Score scheduler for the game. N_SRC requesters (enemy kills, bonus pickups,
// boss hits) ask for point awards. A round-robin arbiter grants one award at a
// time. The award is then added to a two-digit BCD score, one point per clock.
// The score saturates at 99. The block also keeps the session high score and
// drives registered active-low 7-segment codes for both score digits.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset, overrides everything
//   clear       new-game pulse: zeroes the score, keeps the high score
//   req         per-source award request, held by the source until its ack
//   pts         per-source points, slice i = pts[4i+3:4i] (0..15)
//   ack         one-cycle grant pulse per source
//   busy        high while an award is being applied
//   saturated   score has reached 99
//   score_tens  BCD tens digit of the current score
//   score_ones  BCD ones digit of the current score
//   hi_tens     BCD tens digit of the high score
//   hi_ones     BCD ones digit of the high score
//   seven_dis   tens-digit segments, active-low {g,f,e,d,c,b,a}
//   seven_dis1  ones-digit segments, same encoding
// -----------------------------------------------------------------------------
module score_ctrl #(
   parameter int N_SRC = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic [N_SRC-1:0]     req,
   input  logic [4*N_SRC-1:0]   pts,
   output logic [N_SRC-1:0]     ack,
   output logic                 busy,
   output logic                 saturated,
   output logic [3:0]           score_tens,
   output logic [3:0]           score_ones,
   output logic [3:0]           hi_tens,
   output logic [3:0]           hi_ones,
   output logic [6:0]           seven_dis,
   output logic [6:0]           seven_dis1
);

   localparam int RW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int RW1 = RW + 1;
   // Source count at the width of the wrap arithmetic below.
   localparam logic [RW:0] N_W = RW1'(N_SRC);
   localparam logic [6:0]  SEG_ZERO = 7'b1000000;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ADD  = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // BCD increment of a two-digit value. The caller never increments 99,
   // because saturation stops the ADD state before that.
   function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
      logic [7:0] r;
      if (o == 4'd9) begin
         r = {t + 4'd1, 4'd0};
      end else begin
         r = {t, o + 4'd1};
      end
      return r;
   endfunction

   // Active-low {g,f,e,d,c,b,a} encoding of one BCD digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;  // blank; never reached with valid BCD
      endcase
      return s;
   endfunction

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   state_t            state_q,   state_d;
   logic [3:0]        tens_q,    tens_d;
   logic [3:0]        ones_q,    ones_d;
   logic [3:0]        hi_t_q,    hi_t_d;
   logic [3:0]        hi_o_q,    hi_o_d;
   logic [RW-1:0]     rr_q,      rr_d;
   logic [3:0]        rem_q,     rem_d;
   logic [N_SRC-1:0]  ack_q,     ack_d;
   logic              sat_q,     sat_d;
   logic [6:0]        seg_t_q,   seg_t_d;
   logic [6:0]        seg_o_q,   seg_o_d;

   // ---------------------------------------------------------------------------
   // Round-robin arbiter
   // ---------------------------------------------------------------------------
   // The request vector is rotated so that bit 0 is the source under the rr
   // pointer. The lowest set bit of the rotated vector is the winner. The
   // winner's index is then rotated back modulo N_SRC.
   logic [2*N_SRC-1:0] req_dbl;
   logic [N_SRC-1:0]   req_rot;
   logic               found;
   logic [RW:0]        gnt_sum;
   logic [RW-1:0]      gnt;
   logic [RW:0]        rr_inc;
   logic [3:0]         pts_g;

   always_comb begin
      req_dbl = {req, req};
      req_rot = req_dbl[rr_q +: N_SRC];
      found   = 1'b0;
      gnt_sum = '0;
      // Descending scan, so the lowest set offset is the last one written.
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            found   = 1'b1;
            gnt_sum = {1'b0, rr_q} + RW1'(k);
         end
      end
      if (gnt_sum >= N_W) begin
         gnt_sum = gnt_sum - N_W;
      end
      gnt = gnt_sum[RW-1:0];

      rr_inc = {1'b0, gnt} + RW1'(1);
      if (rr_inc == N_W) begin
         rr_inc = '0;
      end

      pts_g = pts[{gnt, 2'b00} +: 4];
   end

   // ---------------------------------------------------------------------------
   // Next-state and award application
   // ---------------------------------------------------------------------------
   logic [7:0] inc;

   always_comb begin
      state_d = state_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      hi_t_d  = hi_t_q;
      hi_o_d  = hi_o_q;
      rr_d    = rr_q;
      rem_d   = rem_q;
      ack_d   = '0;
      sat_d   = sat_q;
      inc     = bcd_inc(tens_q, ones_q);

      // Segments always follow the score register, which gives one cycle of
      // latency after any score change.
      seg_t_d = seg7(tens_q);
      seg_o_d = seg7(ones_q);

      case (state_q)
         S_IDLE: begin
            if (clear) begin
               tens_d = 4'd0;
               ones_d = 4'd0;
               sat_d  = 1'b0;
            end else if (found) begin
               ack_d[gnt] = 1'b1;
               rem_d      = pts_g;
               rr_d       = rr_inc;
               // A zero award, or any award after saturation, is acknowledged
               // but dropped.
               if ((pts_g != 4'd0) && !sat_q) begin
                  state_d = S_ADD;
               end
            end
         end

         S_ADD: begin
            if (clear) begin
               tens_d  = 4'd0;
               ones_d  = 4'd0;
               rem_d   = 4'd0;
               sat_d   = 1'b0;
               state_d = S_IDLE;
            end else begin
               tens_d = inc[7:4];
               ones_d = inc[3:0];
               rem_d  = rem_q - 4'd1;
               // Valid BCD keeps numeric order when compared as a plain byte.
               if (inc > {hi_t_q, hi_o_q}) begin
                  hi_t_d = inc[7:4];
                  hi_o_d = inc[3:0];
               end
               if (inc == 8'h99) begin
                  // Leftover points are discarded once the score hits 99.
                  sat_d   = 1'b1;
                  state_d = S_IDLE;
               end else if (rem_q == 4'd1) begin
                  state_d = S_IDLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Register update
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         hi_t_q  <= 4'd0;
         hi_o_q  <= 4'd0;
         rr_q    <= '0;
         rem_q   <= 4'd0;
         ack_q   <= '0;
         sat_q   <= 1'b0;
         seg_t_q <= SEG_ZERO;
         seg_o_q <= SEG_ZERO;
      end else begin
         state_q <= state_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         hi_t_q  <= hi_t_d;
         hi_o_q  <= hi_o_d;
         rr_q    <= rr_d;
         rem_q   <= rem_d;
         ack_q   <= ack_d;
         sat_q   <= sat_d;
         seg_t_q <= seg_t_d;
         seg_o_q <= seg_o_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign ack        = ack_q;
   assign busy       = (state_q == S_ADD);
   assign saturated  = sat_q;
   assign score_tens = tens_q;
   assign score_ones = ones_q;
   assign hi_tens    = hi_t_q;
   assign hi_ones    = hi_o_q;
   assign seven_dis  = seg_t_q;
   assign seven_dis1 = seg_o_q;

endmodule

// File: tb/tb_score_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_ctrl
//
// Directed bench for score_ctrl. An integer-level model of the score rules runs
// beside the DUT, and every output is compared on every cycle. Hand-computed
// literal checks at key points pin both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_score_ctrl;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             clear;
   logic [N-1:0]     req;
   logic [4*N-1:0]   pts;
   logic [N-1:0]     ack;
   logic             busy;
   logic             saturated;
   logic [3:0]       score_tens, score_ones, hi_tens, hi_ones;
   logic [6:0]       seven_dis, seven_dis1;

   int total = 0;
   int bad   = 0;

   score_ctrl #(.N_SRC(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .req        (req),
      .pts        (pts),
      .ack        (ack),
      .busy       (busy),
      .saturated  (saturated),
      .score_tens (score_tens),
      .score_ones (score_ones),
      .hi_tens    (hi_tens),
      .hi_ones    (hi_ones),
      .seven_dis  (seven_dis),
      .seven_dis1 (seven_dis1)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Model: plain integers for score and high score, and a count of points
   // still to apply (0 = no award running).
   // ---------------------------------------------------------------------------
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   int         m_score = 0;
   int         m_hi    = 0;
   int         m_left  = 0;
   int         m_rr    = 0;
   bit         m_sat   = 1'b0;
   logic [N-1:0] m_ack = '0;
   logic [6:0] m_seg_t = 7'b1000000;
   logic [6:0] m_seg_o = 7'b1000000;

   always @(posedge clk) begin
      int g;
      int p;
      if (rst) begin
         m_score = 0; m_hi = 0; m_left = 0; m_rr = 0; m_sat = 1'b0;
         m_ack = '0; m_seg_t = 7'b1000000; m_seg_o = 7'b1000000;
      end else begin
         m_seg_t = seg_tab[m_score / 10];
         m_seg_o = seg_tab[m_score % 10];
         m_ack   = '0;
         if (m_left == 0) begin
            if (clear) begin
               m_score = 0;
               m_sat   = 1'b0;
            end else if (req != '0) begin
               g = -1;
               for (int k = 0; k < N; k++) begin
                  if (g < 0 && req[(m_rr + k) % N]) g = (m_rr + k) % N;
               end
               m_ack[g] = 1'b1;
               m_rr     = (g + 1) % N;
               p        = int'(pts[4*g +: 4]);
               if (p != 0 && !m_sat) m_left = p;
            end
         end else begin
            if (clear) begin
               m_score = 0;
               m_left  = 0;
               m_sat   = 1'b0;
            end else begin
               m_score = m_score + 1;
               if (m_score > m_hi) m_hi = m_score;
               m_left = m_left - 1;
               if (m_score == 99) begin
                  m_sat  = 1'b1;
                  m_left = 0;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, 1 time unit after the edge.
   always @(posedge clk) begin
      #1;
      chk("ack",        {4'b0, ack},        {4'b0, m_ack});
      chk("busy",       {7'b0, busy},       {7'b0, m_left != 0});
      chk("saturated",  {7'b0, saturated},  {7'b0, m_sat});
      chk("score",      {score_tens, score_ones}, {4'(m_score / 10), 4'(m_score % 10)});
      chk("hi",         {hi_tens, hi_ones},       {4'(m_hi / 10), 4'(m_hi % 10)});
      chk("seven_dis",  {1'b0, seven_dis},  {1'b0, m_seg_t});
      chk("seven_dis1", {1'b0, seven_dis1}, {1'b0, m_seg_o});
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic wait_ack(input int src);
      int n = 0;
      while (ack[src] !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) begin
         total++; bad++;
         $display("FAIL ack_wait src=%0d: got no ack expected ack within 40 cycles", src);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         total++; bad++;
         $display("FAIL idle_wait: got busy=1 expected busy=0 within 40 cycles");
      end
   endtask

   task automatic award(input int src, input int p);
      @(negedge clk);
      pts[4*src +: 4] = 4'(p);
      req[src] = 1'b1;
      wait_ack(src);
      @(negedge clk);
      req[src] = 1'b0;
      wait_idle();
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      logic [N-1:0] first_ack;
      int n;
      rst = 1'b1; clear = 1'b0; req = '0; pts = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("lit_reset_score", {score_tens, score_ones}, 8'h00);
      chk("lit_reset_seg",   {1'b0, seven_dis}, 8'h40);

      // Single award of 3 from source 1.
      award(1, 3);
      chk("lit_score_03",  {score_tens, score_ones}, 8'h03);
      chk("lit_hi_03",     {hi_tens, hi_ones},       8'h03);
      chk("lit_model_03",  8'(m_score), 8'd3);
      chk("lit_seg1_lag",  {1'b0, seven_dis1}, {1'b0, 7'b0100100});
      @(negedge clk);
      chk("lit_seg1_03",   {1'b0, seven_dis1}, {1'b0, 7'b0110000});

      // Reset for two cycles in the middle of an award.
      @(negedge clk);
      pts[3:0] = 4'd9; req[0] = 1'b1;
      wait_ack(0);
      @(negedge clk); req[0] = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      chk("lit_rst_score", {score_tens, score_ones}, 8'h00);
      chk("lit_rst_hi",    {hi_tens, hi_ones},       8'h00);
      chk("lit_rst_busy",  {7'b0, busy},             8'h00);
      chk("lit_rst_segs",  {seven_dis[6:3], seven_dis1[6:3]}, 8'h88);
      @(negedge clk);
      chk("lit_rst_idle",  {7'b0, busy},             8'h00);

      // Sources 0 and 2 together with rr at 0: 0 first, then 2.
      @(negedge clk);
      pts[3:0] = 4'd2; pts[11:8] = 4'd2; req = 4'b0101;
      wait_ack(0);
      chk("lit_rr_first0", {4'b0, ack}, 8'h01);
      @(negedge clk); req[0] = 1'b0;
      wait_ack(2);
      @(negedge clk); req[2] = 1'b0;
      wait_idle();
      chk("lit_score_04",  {score_tens, score_ones}, 8'h04);

      // Sources 0 and 3 together with rr at 3: 3 wins.
      @(negedge clk);
      pts[3:0] = 4'd1; pts[15:12] = 4'd1; req = 4'b1001;
      first_ack = '0;
      n = 0;
      while (ack === '0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      first_ack = ack;
      chk("lit_rr_wrap3",  {4'b0, first_ack}, 8'h08);
      @(negedge clk); req[3] = 1'b0;
      wait_ack(0);
      @(negedge clk); req[0] = 1'b0;
      wait_idle();
      chk("lit_score_06",  {score_tens, score_ones}, 8'h06);

      // Climb to 97, then saturate.
      repeat (6) award(2, 15);
      award(2, 1);
      chk("lit_score_97",  {score_tens, score_ones}, 8'h97);
      award(1, 5);
      chk("lit_score_99",  {score_tens, score_ones}, 8'h99);
      chk("lit_sat",       {7'b0, saturated},       8'h01);
      @(negedge clk);
      chk("lit_seg_99",    {1'b0, seven_dis}, {1'b0, 7'b0010000});
      chk("lit_seg1_99",   {1'b0, seven_dis1}, {1'b0, 7'b0010000});
      award(3, 4);
      chk("lit_sat_hold",  {score_tens, score_ones}, 8'h99);
      chk("lit_hi_99",     {hi_tens, hi_ones},       8'h99);

      // Clear on the third ADD edge of a 6-point award from score 10.
      do_reset();
      award(0, 10);
      chk("lit_score_10",  {score_tens, score_ones}, 8'h10);
      @(negedge clk);
      pts[7:4] = 4'd6; req[1] = 1'b1;
      wait_ack(1);
      @(negedge clk); req[1] = 1'b0;
      @(negedge clk);
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      chk("lit_clr_score", {score_tens, score_ones}, 8'h00);
      chk("lit_clr_busy",  {7'b0, busy},             8'h00);
      chk("lit_clr_hi",    {hi_tens, hi_ones},       8'h12);
      chk("lit_model_hi",  8'(m_hi), 8'd12);
      @(negedge clk);
      chk("lit_clr_seg",   {1'b0, seven_dis},  {1'b0, 7'b1000000});
      chk("lit_clr_seg1",  {1'b0, seven_dis1}, {1'b0, 7'b1000000});

      // Zero-point award, then clear and req in the same IDLE cycle.
      award(2, 0);
      chk("lit_zero_pts",  {score_tens, score_ones}, 8'h00);
      award(1, 2);
      chk("lit_score_02",  {score_tens, score_ones}, 8'h02);
      @(negedge clk);
      clear = 1'b1; pts[15:12] = 4'd5; req[3] = 1'b1;
      @(negedge clk);
      chk("lit_clr_noack", {4'b0, ack}, 8'h00);
      chk("lit_clr_req",   {score_tens, score_ones}, 8'h00);
      clear = 1'b0; req = '0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
